dot_product_accumulator: RTL

- Downstream consumer of sequential_multiplier.
- Accumulates a programmed number of signed products (one per multiplier completion) into a guarded, saturating accumulator, then presents the dot-product result with a one-cycle valid pulse.
- Connects directly to the multiplier's product and done outputs. A level-held done is tolerated.

---
 rtl/dot_product_pkg.sv | 22 ++
 rtl/dot_product_accumulator_sat_add.sv | 31 +++
 rtl/dot_product_accumulator.sv | 102 ++++++++++
 3 files changed

// File: rtl/dot_product_pkg.sv
// Shared types and constants for the dot-product accumulator.
// State encoding, accumulator sizing and default saturation limits.
package dot_product_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int acc_width(input int w, input int guard);
    return 2 * w + guard;
  endfunction

  localparam int DEF_ACC_W = acc_width(32, 8);

  localparam logic [DEF_ACC_W-1:0] SAT_MAX =
    {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic [DEF_ACC_W-1:0] SAT_MIN =
    {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage

// File: rtl/dot_product_accumulator_sat_add.sv
// Combinational signed adder that clamps to the WIDTH-bit range.
// sat_flag marks a result that was clamped.
module sat_add_signed #(
  parameter int WIDTH = 72
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             sat_flag
);

  localparam logic [WIDTH-1:0] MAX_V =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] wide;

  assign wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};

  // Top two bits disagree only when the true sum leaves the range.
  always_comb begin
    sum      = wide[WIDTH-1:0];
    sat_flag = 1'b0;
    if (wide[WIDTH] != wide[WIDTH-1]) begin
      sat_flag = 1'b1;
      sum      = wide[WIDTH] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/dot_product_accumulator.sv
// Accumulates a programmed count of signed multiplier products
// into a guarded saturating sum with a one-cycle done pulse.
module dot_product_accumulator
  import dot_product_pkg::*;
#(
  parameter int W     = 32,
  parameter int GUARD = 8,
  parameter int LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [LEN_W-1:0]       vec_len,
  input  logic                   in_valid,
  input  logic [2*W-1:0]         product,
  output logic [2*W+GUARD-1:0]   acc_out,
  output logic                   acc_valid,
  output logic                   busy,
  output logic [LEN_W-1:0]       count,
  output logic                   overflow
);

  localparam int ACC_W = acc_width(W, GUARD);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic               in_valid_q;
  logic               accept;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum;
  logic               sat_flag;
  logic [LEN_W-1:0]   cnt_inc;

  assign accept   = in_valid & ~in_valid_q;
  assign prod_ext = {{GUARD{product[2*W-1]}}, product};
  assign cnt_inc  = count_q + LEN_W'(1);

  sat_add_signed #(.WIDTH(ACC_W)) u_add (
    .a        (acc_q),
    .b        (prod_ext),
    .sum      (sum),
    .sat_flag (sat_flag)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    // clear wins over a same-cycle accept; that product is dropped
    if (clear) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      len_d   = vec_len;
      state_d = (vec_len != '0) ? ACCUM : DONE;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d   = sum;
            ovf_d   = ovf_q | sat_flag;
            count_d = cnt_inc;
            if (cnt_inc == len_q) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      in_valid_q <= in_valid;
    end
  end

  assign acc_out   = acc_q;
  assign acc_valid = (state_q == DONE);
  assign busy      = (state_q == ACCUM);
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule
